sp_sreg_unit: RTL

//  Holds the core's Stack Pointer (SPL/SPH) and Status Register (SREG), and RAMPZ when enabled.

---
 rtl/avr_core_pkg.sv | 34 +++
 rtl/stk_seq.sv | 96 +++++++++
 rtl/sp_sreg_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/avr_core_pkg.sv
// ============================================================================
//  avr_core_pkg : shared I/O addresses, SREG bit indices and stack FSM states
//  Revision 1.0
// ============================================================================
`default_nettype none

package avr_core_pkg;

   localparam logic [5:0] P_RAMPZ_ADDRESS = 6'h3B;
   localparam logic [5:0] P_SPL           = 6'h3D;
   localparam logic [5:0] P_SPH           = 6'h3E;
   localparam logic [5:0] P_SREG          = 6'h3F;

   localparam int SREG_C = 0;
   localparam int SREG_Z = 1;
   localparam int SREG_N = 2;
   localparam int SREG_V = 3;
   localparam int SREG_S = 4;
   localparam int SREG_H = 5;
   localparam int SREG_T = 6;
   localparam int SREG_I = 7;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PUSH_L = 3'd1,
      PUSH_H = 3'd2,
      POP_H  = 3'd3,
      POP_L  = 3'd4,
      POP_W  = 3'd5
   } stk_state_t;

endpackage

`default_nettype wire

// File: rtl/stk_seq.sv
// ============================================================================
//  stk_seq : CALL/RET stack sequencer pushing/popping the 16-bit return PC
//  Revision 1.0
// ============================================================================
`default_nettype none

module stk_seq
   import avr_core_pkg::*;
#(
   parameter logic [15:0] SP_MASK = 16'h0FFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        call_start,
   input  logic [15:0] ret_pc_in,
   input  logic        ret_start,
   input  logic [15:0] sp,
   input  logic [7:0]  stk_din,
   output logic [15:0] stk_adr,
   output logic        stk_we,
   output logic [7:0]  stk_dout,
   output logic        stk_re,
   output logic        stk_busy,
   output logic [15:0] ret_pc,
   output logic        ret_valid,
   output logic        sp_inc,
   output logic        sp_dec
);

   stk_state_t state;
   logic [7:0] pc_hi;

   // Strobes are registered on entry to each state, so the write/read strobes
   // double as the SP step requests for the parent.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pc_hi     <= 8'h00;
         stk_we    <= 1'b0;
         stk_re    <= 1'b0;
         stk_dout  <= 8'h00;
         ret_pc    <= 16'h0000;
         ret_valid <= 1'b0;
      end else begin
         ret_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (call_start) begin
                  state    <= PUSH_L;
                  pc_hi    <= ret_pc_in[15:8];
                  stk_we   <= 1'b1;
                  stk_dout <= ret_pc_in[7:0];
               end else if (ret_start) begin
                  state  <= POP_H;
                  stk_re <= 1'b1;
               end
            end
            PUSH_L: begin
               state    <= PUSH_H;
               stk_dout <= pc_hi;
            end
            PUSH_H: begin
               state  <= IDLE;
               stk_we <= 1'b0;
            end
            POP_H: begin
               state <= POP_L;
            end
            POP_L: begin
               state        <= POP_W;
               stk_re       <= 1'b0;
               ret_pc[15:8] <= stk_din;
            end
            POP_W: begin
               state       <= IDLE;
               ret_pc[7:0] <= stk_din;
               ret_valid   <= 1'b1;
            end
            default: begin
               state  <= IDLE;
               stk_we <= 1'b0;
               stk_re <= 1'b0;
            end
         endcase
      end
   end

   // Pops pre-increment: the byte above the current SP is the one read.
   assign stk_adr  = stk_re ? ((sp + 16'd1) & SP_MASK) : sp;
   assign stk_busy = (state != IDLE);
   assign sp_dec   = stk_we;
   assign sp_inc   = stk_re;

endmodule

`default_nettype wire

// File: rtl/sp_sreg_unit.sv
// ============================================================================
//  sp_sreg_unit : stack pointer, status register, optional RAMPZ (AVR_RAMPZ_EN)
//  Revision 1.0
// ============================================================================
`default_nettype none

module sp_sreg_unit
   import avr_core_pkg::*;
#(
   parameter logic [15:0] SP_RESET = 16'h08FF,
   parameter logic [15:0] SP_MASK  = 16'h0FFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  adr,
   input  logic        iowe,
   input  logic [7:0]  dbusout,
   input  logic [7:0]  sreg_we,
   input  logic [7:0]  sreg_alu,
   input  logic        irq_ack,
   input  logic        reti,
   input  logic        call_start,
   input  logic [15:0] ret_pc_in,
   input  logic        ret_start,
   input  logic [7:0]  stk_din,
   output logic [15:0] stk_adr,
   output logic        stk_we,
   output logic [7:0]  stk_dout,
   output logic        stk_re,
   output logic        stk_busy,
   output logic [15:0] ret_pc,
   output logic        ret_valid,
   output logic [7:0]  spl_out,
   output logic [7:0]  sph_out,
   output logic [7:0]  sreg_out,
   output logic [7:0]  rampz_out
);

   logic [15:0] sp;
   logic [7:0]  sreg;
   logic [7:0]  sreg_next;
   logic        sp_inc;
   logic        sp_dec;
   logic        wr_spl;
   logic        wr_sph;
   logic        wr_sreg;

   assign wr_spl  = iowe && (adr == P_SPL);
   assign wr_sph  = iowe && (adr == P_SPH);
   assign wr_sreg = iowe && (adr == P_SREG);

   stk_seq #(
      .SP_MASK (SP_MASK)
   ) u_stk_seq (
      .clk        (clk),
      .rst        (rst),
      .call_start (call_start),
      .ret_pc_in  (ret_pc_in),
      .ret_start  (ret_start),
      .sp         (sp),
      .stk_din    (stk_din),
      .stk_adr    (stk_adr),
      .stk_we     (stk_we),
      .stk_dout   (stk_dout),
      .stk_re     (stk_re),
      .stk_busy   (stk_busy),
      .ret_pc     (ret_pc),
      .ret_valid  (ret_valid),
      .sp_inc     (sp_inc),
      .sp_dec     (sp_dec)
   );

   // Sequencer steps own SP; software writes land only while it is idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp <= SP_RESET & SP_MASK;
      end else if (sp_dec) begin
         sp <= (sp - 16'd1) & SP_MASK;
      end else if (sp_inc) begin
         sp <= (sp + 16'd1) & SP_MASK;
      end else if (!stk_busy) begin
         if (wr_spl) begin
            sp <= {sp[15:8], dbusout} & SP_MASK;
         end else if (wr_sph) begin
            sp <= {dbusout, sp[7:0]} & SP_MASK;
         end
      end
   end

   // Applied lowest priority first so later assignments override.
   always_comb begin
      sreg_next = (sreg & ~sreg_we) | (sreg_alu & sreg_we);
      if (reti) begin
         sreg_next[SREG_I] = 1'b1;
      end
      if (wr_sreg) begin
         sreg_next = dbusout;
      end
      if (irq_ack) begin
         sreg_next[SREG_I] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= 8'h00;
      end else begin
         sreg <= sreg_next;
      end
   end

`ifdef AVR_RAMPZ_EN
   logic [7:0] rampz;

   always_ff @(posedge clk) begin
      if (rst) begin
         rampz <= 8'h00;
      end else if (iowe && (adr == P_RAMPZ_ADDRESS)) begin
         rampz <= dbusout;
      end
   end

   assign rampz_out = rampz;
`else
   assign rampz_out = 8'h00;
`endif

   assign spl_out  = sp[7:0];
   assign sph_out  = sp[15:8];
   assign sreg_out = sreg;

endmodule

`default_nettype wire
